// File: rtl/toast_fetch_buffer_pkg.sv
// ============================================================================
// toast_fetch_buffer_pkg : constants shared by the IF/ID fetch buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package toast_fetch_buffer_pkg;

   // addi x0, x0, 0 -- presented to ID whenever the buffer is empty
   localparam logic [31:0] TOAST_NOP      = 32'h0000_0013;
   localparam int          TOAST_FB_DEPTH = 4;

endpackage

`default_nettype wire

// File: rtl/toast_fb_regfile.sv
// ============================================================================
// toast_fb_regfile : DEPTH x WIDTH storage, one write port, async read port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module toast_fb_regfile
   import toast_fetch_buffer_pkg::*;
#(
   parameter int WIDTH      = 64,
   parameter int DEPTH      = TOAST_FB_DEPTH,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data
);

   // Storage is intentionally unreset; the owner masks reads when empty.
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/toast_fetch_buffer.sv
// ============================================================================
// toast_fetch_buffer : FWFT FIFO of (instruction, PC) pairs between IF and ID.
// Revision: 1.0
// ============================================================================
`default_nettype none

module toast_fetch_buffer
   import toast_fetch_buffer_pkg::*;
#(
   parameter int REG_DATA_WIDTH = 32,
   parameter int DEPTH          = TOAST_FB_DEPTH,
   parameter int CNT_WIDTH      = $clog2(DEPTH) + 1
) (
   input  logic                      clk_i,
   input  logic                      resetn_i,
   input  logic                      IF_valid_i,
   input  logic [REG_DATA_WIDTH-1:0] IF_instruction_i,
   input  logic [REG_DATA_WIDTH-1:0] IF_pc_i,
   output logic                      IF_ready_o,
   output logic                      ID_valid_o,
   output logic [REG_DATA_WIDTH-1:0] ID_instruction_o,
   output logic [REG_DATA_WIDTH-1:0] ID_pc_o,
   input  logic                      ID_ready_i,
   input  logic                      flush_i,
   output logic [CNT_WIDTH-1:0]      count_o
);

   localparam int PTR_WIDTH = $clog2(DEPTH);

   logic [PTR_WIDTH-1:0]        wr_ptr;
   logic [PTR_WIDTH-1:0]        rd_ptr;
   logic [CNT_WIDTH-1:0]        count;
   logic                        push;
   logic                        pop;
   logic [2*REG_DATA_WIDTH-1:0] head;

   // Status comes from the count register only, so no input reaches an output.
   assign IF_ready_o = (count < CNT_WIDTH'(DEPTH));
   assign ID_valid_o = (count != '0);
   assign count_o    = count;

   assign push = IF_valid_i & IF_ready_o & ~flush_i;
   assign pop  = ID_valid_o & ID_ready_i & ~flush_i;

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_WIDTH'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_WIDTH'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_WIDTH'(1);
            2'b01:   count <= count - CNT_WIDTH'(1);
            default: count <= count;
         endcase
      end
   end

   toast_fb_regfile #(
      .WIDTH (2 * REG_DATA_WIDTH),
      .DEPTH (DEPTH)
   ) u_regfile (
      .clk     (clk_i),
      .wr_en   (push),
      .wr_addr (wr_ptr),
      .wr_data ({IF_instruction_i, IF_pc_i}),
      .rd_addr (rd_ptr),
      .rd_data (head)
   );

   always_comb begin
      ID_instruction_o = REG_DATA_WIDTH'(TOAST_NOP);
      ID_pc_o          = '0;
      if (ID_valid_o) begin
         ID_instruction_o = head[2*REG_DATA_WIDTH-1:REG_DATA_WIDTH];
         ID_pc_o          = head[REG_DATA_WIDTH-1:0];
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_toast_fetch_buffer.sv
// ============================================================================
// tb_toast_fetch_buffer : directed scoreboard bench for toast_fetch_buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_toast_fetch_buffer;

   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam int          DEPTH = 4;

   logic        clk = 1'b0;
   logic        resetn_i;
   logic        IF_valid_i;
   logic [31:0] IF_instruction_i;
   logic [31:0] IF_pc_i;
   logic        IF_ready_o;
   logic        ID_valid_o;
   logic [31:0] ID_instruction_o;
   logic [31:0] ID_pc_o;
   logic        ID_ready_i;
   logic        flush_i;
   logic [2:0]  count_o;

   int checks = 0;
   int errors = 0;

   // Expected contents, head at index 0: {instruction, pc}
   logic [63:0] sb[$];

   always #5 clk = ~clk;

   toast_fetch_buffer #(
      .REG_DATA_WIDTH (32),
      .DEPTH          (DEPTH),
      .CNT_WIDTH      (3)
   ) dut (
      .clk_i            (clk),
      .resetn_i         (resetn_i),
      .IF_valid_i       (IF_valid_i),
      .IF_instruction_i (IF_instruction_i),
      .IF_pc_i          (IF_pc_i),
      .IF_ready_o       (IF_ready_o),
      .ID_valid_o       (ID_valid_o),
      .ID_instruction_o (ID_instruction_o),
      .ID_pc_o          (ID_pc_o),
      .ID_ready_i       (ID_ready_i),
      .flush_i          (flush_i),
      .count_o          (count_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge: drive, check against the scoreboard, advance one clock.
   task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic rdy, input logic fl);
      int n;
      IF_valid_i       = v;
      IF_instruction_i = ins;
      IF_pc_i          = pc;
      ID_ready_i       = rdy;
      flush_i          = fl;
      #1;
      n = sb.size();
      chk("count", {29'b0, count_o}, 32'(n));
      chk("id_valid", {31'b0, ID_valid_o}, {31'b0, (n != 0)});
      chk("if_ready", {31'b0, IF_ready_o}, {31'b0, (n < DEPTH)});
      if (n == 0) begin
         chk("empty_instr", ID_instruction_o, NOP);
         chk("empty_pc", ID_pc_o, 32'h0);
      end else begin
         chk("head_instr", ID_instruction_o, sb[0][63:32]);
         chk("head_pc", ID_pc_o, sb[0][31:0]);
      end
      if (fl) begin
         sb.delete();
      end else begin
         if (rdy && n != 0) void'(sb.pop_front());
         if (v && n < DEPTH) sb.push_back({ins, pc});
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input logic rdy);
      cyc(1'b0, 32'h0, 32'h0, rdy, 1'b0);
   endtask

   initial begin
      resetn_i         = 1'b0;
      IF_valid_i       = 1'b0;
      IF_instruction_i = '0;
      IF_pc_i          = '0;
      ID_ready_i       = 1'b0;
      flush_i          = 1'b0;
      repeat (2) @(negedge clk);
      resetn_i = 1'b1;

      // Reset state while idle
      idle(1'b0);
      idle(1'b0);

      // Two pushes under back-pressure, then drain in order
      cyc(1'b1, 32'h0050_0093, 32'h0, 1'b0, 1'b0);
      cyc(1'b1, 32'h0010_0113, 32'h4, 1'b0, 1'b0);
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);

      // Fill, overfill attempt, single pop, then drain
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 32'h1000_0013 + 32'(i), 32'h100 + 32'(4 * i), 1'b0, 1'b0);
      end
      cyc(1'b1, 32'hDEAD_BEEF, 32'h200, 1'b0, 1'b0);
      idle(1'b1);
      idle(1'b0);
      for (int i = 0; i < 4; i++) idle(1'b1);

      // Sustained push+pop at count 2 across pointer wrap
      cyc(1'b1, 32'h2000_0013, 32'h300, 1'b0, 1'b0);
      cyc(1'b1, 32'h2000_0113, 32'h304, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 32'h2100_0013 + 32'(i), 32'h308 + 32'(4 * i), 1'b1, 1'b0);
      end
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);

      // Flush at count 3 together with an incoming word
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 32'h3000_0013 + 32'(i), 32'h400 + 32'(4 * i), 1'b0, 1'b0);
      end
      cyc(1'b1, 32'hBADB_AD00, 32'h40C, 1'b1, 1'b1);
      idle(1'b1);
      cyc(1'b1, 32'h3100_0013, 32'h500, 1'b0, 1'b0);
      idle(1'b1);
      idle(1'b1);

      // Asynchronous reset mid-operation at count 3, checked before any edge
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 32'h4000_0013 + 32'(i), 32'h600 + 32'(4 * i), 1'b0, 1'b0);
      end
      IF_valid_i = 1'b0;
      #2 resetn_i = 1'b0;
      #1;
      chk("rst_id_valid", {31'b0, ID_valid_o}, 32'h0);
      chk("rst_instr", ID_instruction_o, NOP);
      chk("rst_pc", ID_pc_o, 32'h0);
      chk("rst_if_ready", {31'b0, IF_ready_o}, 32'h1);
      chk("rst_count", {29'b0, count_o}, 32'h0);
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      resetn_i = 1'b1;
      cyc(1'b1, 32'h5000_0013, 32'h700, 1'b0, 1'b0);
      idle(1'b1);
      idle(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
